key_sw_ctrl: RTL and testbench
==============================

Name: key_sw_ctrl

Overview:
- Memory-mapped input controller for the DE0-CV keys and switches.
- Synchronises and debounces KEY[3:0] and SW[9:0], holds the debounced values in data registers, and tracks new-data Ready/Overrun status per device.
- Sits between the board pins and the processor bus.
- Replaces the processor's raw combinational KEY/SW reads at ADDRKEY/ADDRSW, and adds control registers at +4 and an interrupt request.

Parameters:
- DBITS, 32, bus data width.
- ADDRKEY, 32'hFFFFF080, KDATA address; KCTRL is at ADDRKEY+4.
- ADDRSW, 32'hFFFFF090, SDATA address; SCTRL is at ADDRSW+4.
- DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles required before a debounced value updates (20 ms at 50 MHz).
- CNTBITS, 20, debounce counter width; must satisfy 2^CNTBITS > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  processor clock, rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- KEY  in  4  raw keys, active-low (0 = pressed).
- SW  in  10  raw switches.
- addr  in  DBITS  bus address (MAR).
- wdata  in  DBITS  write data (thebus).
- we  in  1  write strobe (WrMem), one cycle.
- re  in  1  read strobe (DrMem), one cycle.
- rdata  out  DBITS  combinational read data.
- sel  out  1  addr matches one of the four registers (combinational).
- irq  out  1  interrupt request.

Behaviour:

Synchronisation
- Each group (4 keys as ~KEY, 10 switches) passes through a 2-FF synchroniser, giving sync value s.
- Keys are inverted before debouncing, so 1 = pressed.

Debounce (per group, identical logic)
- Registers: cand, deb, cnt.
- If s != cand: cand <= s, cnt <= 0.
- Else if cand != deb and cnt == DEBOUNCE_CYCLES-1: deb <= cand, cnt <= 0, pulse event for one cycle.
- Else if cand != deb: cnt <= cnt+1.
- Else: cnt holds 0.
- Latency: a stable pin change reaches deb 2 + 1 + DEBOUNCE_CYCLES cycles after the pin edge.
- A glitch shorter than DEBOUNCE_CYCLES never changes deb.

Register map
- KDATA: {28'b0, debK}, read-only; writes ignored.
- KCTRL: bit0 Ready (RO), bit1 Overrun (write 0 clears, write 1 ignored), bit4 IE (R/W); all other bits read 0.
- SDATA: {22'b0, debS}, read-only.
- SCTRL: same layout as KCTRL.

Ready / Overrun (per group)
- Ready sets on event.
- Ready clears when re=1 and addr==xDATA.
- Overrun sets when event occurs while Ready=1 and no clearing read happens in the same cycle.
- Event and clearing read in the same cycle: Ready stays 1, Overrun unchanged.
- Write clearing Overrun and event in the same cycle: Overrun follows the event rule (set wins).
- Reads of CTRL registers have no side effects.

Bus timing
- rdata = selected register when sel=1, else 0.
- Purely combinational from addr; valid in the same cycle re is asserted.
- State updates from re/we take effect at the next rising clk edge.
- we and re asserted together at one address is treated as a write only.

Interrupt
- irq = (KReady & KIE) | (SReady & SIE), registered, one-cycle lag.

Reset (RESET_N=0, asynchronous)
- Synchronisers, cand, deb and cnt clear to 0.
- Ready, Overrun, IE clear to 0; irq = 0.
- Switches already on at reset debounce normally afterwards, then set SReady once.
- Reset asserted mid-count abandons the count; no event fires.

Test Plan:
(Bench uses DEBOUNCE_CYCLES=4, CNTBITS=3.)
1. Reset, then KEY=4'b1111, SW=0 held -> KDATA=0, SDATA=0, KCTRL=0, SCTRL=0, irq=0 for 50 cycles.
2. KEY=4'b1110 held, with edge at cycle 0 -> KDATA reads 0x1 and KCTRL=0x1 from cycle 7 (not before); read KDATA -> next cycle KCTRL=0x0.
3. SW toggles 0x001 for 3 cycles then back to 0 -> SDATA stays 0, SCTRL Ready stays 0.
4. Write SCTRL=0x10; set SW=0x2A5 and hold -> SDATA=0x2A5, Ready=1, irq=1 one cycle later; change SW to 0x000 without reading -> SCTRL=0x13; write SCTRL=0x10 -> Overrun clears, Ready remains 1.
5. Event cycle coincides with a KDATA read -> KCTRL Ready=1, Overrun=0.
6. Drop RESET_N asynchronously between clock edges mid-count and mid-Ready -> all outputs 0 immediately; addr=0x00001000 -> sel=0, rdata=0.

Source files
------------

// File: rtl/key_sw_ctrl.sv
// key_sw_ctrl: synchronised, debounced KEY/SW data registers with ready/overrun status and irq
module key_sw_deb #(
    parameter int W   = 4,
    parameter int CYC = 1000000,
    parameter int CB  = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] deb,
    output logic         ev
);
    logic [W-1:0]  s1;
    logic [W-1:0]  s;
    logic [W-1:0]  cand;
    logic [CB-1:0] cnt;
    logic          stable;
    logic          pend;
    assign stable = s == cand;
    assign pend   = cand != deb;
    // ev is combinational so Ready sets on the same edge that deb takes the new value
    assign ev     = stable && pend && cnt == CB'(CYC - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= '0;
            s    <= '0;
            cand <= '0;
            deb  <= '0;
            cnt  <= '0;
        end else begin
            s1 <= raw;
            s  <= s1;
            if (!stable) begin
                cand <= s;
                cnt  <= '0;
            end else if (ev) begin
                deb <= cand;
                cnt <= '0;
            end else if (pend) begin
                cnt <= cnt + 1'b1;
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module key_sw_stat (
    input  logic clk,
    input  logic rst_n,
    input  logic ev,
    input  logic rd,
    input  logic wr,
    input  logic ovr_wr,
    input  logic ie_wr,
    output logic rdy,
    output logic ovr,
    output logic ie
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy <= 1'b0;
            ovr <= 1'b0;
            ie  <= 1'b0;
        end else begin
            rdy <= ev || (rdy && !rd);
            ovr <= (ev && rdy && !rd) || (ovr && !(wr && !ovr_wr));
            ie  <= wr ? ie_wr : ie;
        end
    end
endmodule

module key_sw_ctrl #(
    parameter int               DBITS           = 32,
    parameter logic [DBITS-1:0] ADDRKEY         = 32'hFFFFF080,
    parameter logic [DBITS-1:0] ADDRSW          = 32'hFFFFF090,
    parameter int               DEBOUNCE_CYCLES = 1000000,
    parameter int               CNTBITS         = 20
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    input  logic [DBITS-1:0] addr,
    input  logic [DBITS-1:0] wdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    output logic             sel,
    output logic             irq
);
    logic [3:0] deb_k;
    logic [9:0] deb_s;
    logic       ev_k;
    logic       ev_s;
    logic       hit_kd;
    logic       hit_kc;
    logic       hit_sd;
    logic       hit_sc;
    logic       k_rdy;
    logic       k_ovr;
    logic       k_ie;
    logic       s_rdy;
    logic       s_ovr;
    logic       s_ie;
    logic       unused_wdata;
    assign hit_kd       = addr == ADDRKEY;
    assign hit_kc       = addr == ADDRKEY + DBITS'(4);
    assign hit_sd       = addr == ADDRSW;
    assign hit_sc       = addr == ADDRSW + DBITS'(4);
    assign sel          = hit_kd || hit_kc || hit_sd || hit_sc;
    assign unused_wdata = ^{wdata[DBITS-1:5], wdata[3:2], wdata[0]};
    key_sw_deb #(.W(4), .CYC(DEBOUNCE_CYCLES), .CB(CNTBITS)) u_kdeb (
        .clk   (clk),
        .rst_n (RESET_N),
        .raw   (~KEY),
        .deb   (deb_k),
        .ev    (ev_k)
    );
    key_sw_deb #(.W(10), .CYC(DEBOUNCE_CYCLES), .CB(CNTBITS)) u_sdeb (
        .clk   (clk),
        .rst_n (RESET_N),
        .raw   (SW),
        .deb   (deb_s),
        .ev    (ev_s)
    );
    // a cycle with both we and re is a write, so it never consumes Ready
    key_sw_stat u_kst (
        .clk    (clk),
        .rst_n  (RESET_N),
        .ev     (ev_k),
        .rd     (re && !we && hit_kd),
        .wr     (we && hit_kc),
        .ovr_wr (wdata[1]),
        .ie_wr  (wdata[4]),
        .rdy    (k_rdy),
        .ovr    (k_ovr),
        .ie     (k_ie)
    );
    key_sw_stat u_sst (
        .clk    (clk),
        .rst_n  (RESET_N),
        .ev     (ev_s),
        .rd     (re && !we && hit_sd),
        .wr     (we && hit_sc),
        .ovr_wr (wdata[1]),
        .ie_wr  (wdata[4]),
        .rdy    (s_rdy),
        .ovr    (s_ovr),
        .ie     (s_ie)
    );
    always_comb begin
        rdata = hit_kd ? DBITS'(deb_k) :
                hit_kc ? DBITS'({k_ie, 2'b00, k_ovr, k_rdy}) :
                hit_sd ? DBITS'(deb_s) :
                hit_sc ? DBITS'({s_ie, 2'b00, s_ovr, s_rdy}) : '0;
    end
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) irq <= 1'b0;
        else          irq <= (k_rdy && k_ie) || (s_rdy && s_ie);
    end
endmodule

// File: tb/tb_key_sw_ctrl.sv
// tb_key_sw_ctrl: directed, table-driven and randomized checks of key_sw_ctrl against a window-based model
module tb_key_sw_ctrl;
    localparam int          DC = 4;
    localparam int          HN = DC + 2;
    localparam logic [31:0] KD = 32'hFFFFF080;
    localparam logic [31:0] KC = 32'hFFFFF084;
    localparam logic [31:0] SD = 32'hFFFFF090;
    localparam logic [31:0] SC = 32'hFFFFF094;
    localparam logic [31:0] REGS [5] = '{KD, KC, SD, SC, 32'h00001000};

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic        s;
        logic [31:0] r;
    } vec_t;

    logic        clk = 1'b0;
    logic        RESET_N = 1'b0;
    logic [3:0]  KEY = 4'hF;
    logic [9:0]  SW = '0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;
    int          n_tests = 0;
    int          n_fail = 0;

    // model: deb takes a new value once DC+1 consecutive pin samples, two edges old, agree
    logic [3:0]  hk [HN];
    logic [9:0]  hs [HN];
    logic [3:0]  m_dk;
    logic [9:0]  m_ds;
    logic [1:0]  m_rdy;
    logic [1:0]  m_ovr;
    logic [1:0]  m_ie;
    logic        m_irq;
    vec_t        tbl [15];

    key_sw_ctrl #(.DEBOUNCE_CYCLES(DC), .CNTBITS(3)) dut (
        .clk     (clk),
        .RESET_N (RESET_N),
        .KEY     (KEY),
        .SW      (SW),
        .addr    (addr),
        .wdata   (wdata),
        .we      (we),
        .re      (re),
        .rdata   (rdata),
        .sel     (sel),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int i = 0; i < HN; i++) begin
            hk[i] = '0;
            hs[i] = '0;
        end
        m_dk = '0;
        m_ds = '0;
        m_rdy = '0;
        m_ovr = '0;
        m_ie = '0;
        m_irq = 1'b0;
    endtask

    task automatic model_tick();
        logic [1:0] ev;
        logic [1:0] rd;
        logic [1:0] wr;
        logic       nirq;
        ev[0] = hk[1] != m_dk;
        ev[1] = hs[1] != m_ds;
        for (int i = 2; i < HN; i++) begin
            if (hk[i] != hk[1]) ev[0] = 1'b0;
            if (hs[i] != hs[1]) ev[1] = 1'b0;
        end
        rd = {re && !we && addr == SD, re && !we && addr == KD};
        wr = {we && addr == SC, we && addr == KC};
        nirq = |(m_rdy & m_ie);
        for (int g = 0; g < 2; g++) begin
            if (ev[g] && m_rdy[g] && !rd[g]) m_ovr[g] = 1'b1;
            else if (wr[g] && !wdata[1]) m_ovr[g] = 1'b0;
            m_rdy[g] = ev[g] || (m_rdy[g] && !rd[g]);
            if (wr[g]) m_ie[g] = wdata[4];
        end
        if (ev[0]) m_dk = hk[1];
        if (ev[1]) m_ds = hs[1];
        for (int i = HN - 1; i > 0; i--) begin
            hk[i] = hk[i-1];
            hs[i] = hs[i-1];
        end
        hk[0] = ~KEY;
        hs[0] = SW;
        m_irq = nirq;
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (a == KD) return 32'(m_dk);
        if (a == KC) return 32'({m_ie[0], 2'b00, m_ovr[0], m_rdy[0]});
        if (a == SD) return 32'(m_ds);
        if (a == SC) return 32'({m_ie[1], 2'b00, m_ovr[1], m_rdy[1]});
        return '0;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        model_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(name, rdata, exp);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wdata = d;
        we = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rd_reg(input logic [31:0] a);
        addr = a;
        re = 1'b1;
        step();
        re = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{KD, 1'b0, 32'h0,        1'b1, 32'h0};
        tbl[1]  = '{KC, 1'b1, 32'h12,       1'b1, 32'h0};
        tbl[2]  = '{KC, 1'b0, 32'h0,        1'b1, 32'h10};
        tbl[3]  = '{KD, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0};
        tbl[4]  = '{KD, 1'b0, 32'h0,        1'b1, 32'h0};
        tbl[5]  = '{SC, 1'b1, 32'hFFFFFFFF, 1'b1, 32'h0};
        tbl[6]  = '{SC, 1'b0, 32'h0,        1'b1, 32'h10};
        tbl[7]  = '{SD, 1'b0, 32'h0,        1'b1, 32'h0};
        tbl[8]  = '{KC, 1'b1, 32'h0,        1'b1, 32'h10};
        tbl[9]  = '{KC, 1'b0, 32'h0,        1'b1, 32'h0};
        tbl[10] = '{SC, 1'b1, 32'h0,        1'b1, 32'h10};
        tbl[11] = '{SC, 1'b0, 32'h0,        1'b1, 32'h0};
        tbl[12] = '{32'h00001000, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[13] = '{32'hFFFFF088, 1'b0, 32'h0, 1'b0, 32'h0};
        tbl[14] = '{32'hFFFFF081, 1'b0, 32'h0, 1'b0, 32'h0};
        model_reset();
        #12 RESET_N = 1'b1;
        step();

        for (int i = 0; i < 50; i++) begin
            chk_reg("t1_kdata", KD, 32'h0);
            chk_reg("t1_kctrl", KC, 32'h0);
            chk_reg("t1_sdata", SD, 32'h0);
            chk_reg("t1_sctrl", SC, 32'h0);
            check("t1_irq", 32'(irq), 32'h0);
            step();
        end

        foreach (tbl[i]) begin
            addr = tbl[i].a;
            wdata = tbl[i].d;
            we = tbl[i].w;
            #1;
            check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].s));
            check($sformatf("tbl%0d_rdata", i), rdata, tbl[i].r);
            step();
            we = 1'b0;
        end

        KEY = 4'hE;
        for (int i = 0; i <= 7; i++) begin
            if (i > 0) step();
            chk_reg($sformatf("t2_kdata_c%0d", i), KD, (i == 7) ? 32'h1 : 32'h0);
            chk_reg($sformatf("t2_kctrl_c%0d", i), KC, (i == 7) ? 32'h1 : 32'h0);
        end
        check("t2_irq", 32'(irq), 32'h0);
        rd_reg(KD);
        chk_reg("t2_kctrl_after_read", KC, 32'h0);
        chk_reg("t2_kdata_after_read", KD, 32'h1);

        SW = 10'h001;
        repeat (3) step();
        SW = 10'h000;
        for (int i = 0; i < 12; i++) begin
            chk_reg("t3_sdata", SD, 32'h0);
            chk_reg("t3_sctrl", SC, 32'h0);
            step();
        end

        wr_reg(SC, 32'h10);
        chk_reg("t4_sctrl_ie", SC, 32'h10);
        SW = 10'h2A5;
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i < 7) chk_reg("t4_sdata_early", SD, 32'h0);
        end
        chk_reg("t4_sdata", SD, 32'h2A5);
        chk_reg("t4_sctrl_ready", SC, 32'h11);
        check("t4_irq_lag", 32'(irq), 32'h0);
        step();
        check("t4_irq", 32'(irq), 32'h1);
        SW = 10'h000;
        repeat (7) step();
        chk_reg("t4_sdata_zero", SD, 32'h0);
        chk_reg("t4_sctrl_ovr", SC, 32'h13);
        wr_reg(SC, 32'h12);
        chk_reg("t4_ovr_w1_ignored", SC, 32'h13);
        wr_reg(SC, 32'h10);
        chk_reg("t4_ovr_cleared", SC, 32'h11);
        rd_reg(SD);
        chk_reg("t4_sctrl_read", SC, 32'h10);
        step();
        check("t4_irq_off", 32'(irq), 32'h0);
        wr_reg(SC, 32'h0);

        KEY = 4'hF;
        repeat (7) step();
        chk_reg("t5_kdata_rel", KD, 32'h0);
        chk_reg("t5_kctrl_rel", KC, 32'h1);
        KEY = 4'hE;
        repeat (6) step();
        rd_reg(KD);
        chk_reg("t5_kdata", KD, 32'h1);
        chk_reg("t5_kctrl_coincide", KC, 32'h1);

        wr_reg(KC, 32'h10);
        step();
        check("t6_irq_pre", 32'(irq), 32'h1);
        SW = 10'h3FF;
        repeat (4) step();
        #3 RESET_N = 1'b0;
        #1;
        model_reset();
        addr = 32'h00001000;
        #1;
        check("t6_sel", 32'(sel), 32'h0);
        check("t6_rdata", rdata, 32'h0);
        check("t6_irq", 32'(irq), 32'h0);
        chk_reg("t6_kdata", KD, 32'h0);
        chk_reg("t6_kctrl", KC, 32'h0);
        chk_reg("t6_sdata", SD, 32'h0);
        chk_reg("t6_sctrl", SC, 32'h0);
        repeat (2) @(posedge clk);
        #3 RESET_N = 1'b1;
        chk_reg("t6_sdata_rel", SD, 32'h0);
        for (int i = 1; i <= 7; i++) begin
            step();
            if (i < 7) chk_reg("t6_sctrl_early", SC, 32'h0);
        end
        chk_reg("t6_sdata_on", SD, 32'h3FF);
        chk_reg("t6_sctrl_on", SC, 32'h1);
        chk_reg("t6_kdata_on", KD, 32'h1);
        chk_reg("t6_kctrl_on", KC, 32'h1);
        rd_reg(SD);
        for (int i = 0; i < 20; i++) begin
            chk_reg("t6_sready_once", SC, 32'h0);
            step();
        end

        begin
            int hold_k = 0;
            int hold_s = 0;
            int op;
            for (int c = 0; c < 3000; c++) begin
                if (hold_k == 0) begin
                    KEY = 4'($urandom);
                    hold_k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 20);
                end
                if (hold_s == 0) begin
                    SW = 10'($urandom);
                    hold_s = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : $urandom_range(5, 20);
                end
                hold_k--;
                hold_s--;
                op = $urandom_range(0, 9);
                addr = REGS[($urandom_range(0, 7) == 0) ? 4 : $urandom_range(0, 3)];
                wdata = $urandom;
                we = op == 0 || op == 4;
                re = op >= 1 && op <= 4;
                #1;
                check("rnd_rdata", rdata, m_read(addr));
                check("rnd_sel", 32'(sel), 32'(addr != REGS[4]));
                check("rnd_irq", 32'(irq), 32'(m_irq));
                step();
                we = 1'b0;
                re = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
